// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             a0, b0;
  logic             dBit;
  logic             brNxt;
  logic [WIDTH-1:0] resShifted;

  // One full-subtractor cell applied to the current LSBs and the held borrow.
  assign a0         = aSh_q[0];
  assign b0         = bSh_q[0];
  assign dBit       = a0 ^ b0 ^ br_q;
  assign brNxt      = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign resShifted = {dBit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start directly so back-to-back ops lose no cycle.
        if (start) begin
          state_d = S_RUN;
          aSh_d   = a;
          bSh_d   = b;
          br_d    = bin;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = resShifted;
        br_d  = brNxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          diff_d  = resShifted;
          bout_d  = brNxt;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake outputs are pure state decodes, so start has no path to them.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8), with a
// short randomized tail checked against a modular-arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, verify busy length, latency, result and single done pulse.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic binv, input logic [W-1:0] expDiff,
                               input logic expBout, input string tag);
    int n;
    int busyCycles;
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = binv;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    n          = 0;
    busyCycles = 0;
    while (!done && n < 20) begin
      if (busy) busyCycles++;
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, n, W);
    checkOutput({tag, "_busy"}, busyCycles, W);
    checkOutput({tag, "_diff"}, diff, expDiff);
    checkOutput({tag, "_bout"}, bout, expBout);
    tick();
    checkOutput({tag, "_donePulse"}, done, 0);
  endtask

  initial begin
    logic [W:0] ref9;
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W-1:0] opA [4];
    logic [W-1:0] opB [4];
    logic [W-1:0] opD [4];
    int n;
    int extraDone;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    rst_n    = 1'b0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_diff", diff, 0);
    checkOutput("reset_bout", bout, 0);
    rst_n = 1'b1;
    tick();

    // Basic op and result hold through idle cycles.
    applyStimulus(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, "t1");
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t1_holdDiff", diff, 63);
      checkOutput("t1_holdBout", bout, 0);
    end

    // Boundary operands.
    applyStimulus(8'd5,   8'd9,   1'b0, 8'd252, 1'b1, "t2a");
    applyStimulus(8'd0,   8'd0,   1'b1, 8'd255, 1'b1, "t2b");
    applyStimulus(8'd255, 8'd255, 1'b0, 8'd0,   1'b0, "t2c");
    applyStimulus(8'd255, 8'd0,   1'b1, 8'd254, 1'b0, "t2d");

    // start during RUN is ignored.
    start = 1'b1; a = 8'd200; b = 8'd50; bin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'd1; b = 8'd1;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t3_latency", n, W);
    checkOutput("t3_diff", diff, 150);
    checkOutput("t3_bout", bout, 0);
    extraDone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) extraDone++;
    end
    checkOutput("t3_noSecondOp", extraDone, 0);

    // Asynchronous reset mid-RUN.
    start = 1'b1; a = 8'd77; b = 8'd11; bin = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("t4_busyBefore", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_diff", diff, 0);
    checkOutput("t4_bout", bout, 0);
    tick(); tick();
    #2;
    rst_n = 1'b1;
    tick();
    applyStimulus(8'd10, 8'd3, 1'b0, 8'd7, 1'b0, "t4_after");

    // Back-to-back with start held high.
    opA[0] = 8'd20;  opB[0] = 8'd5;   opD[0] = 8'd15;
    opA[1] = 8'd3;   opB[1] = 8'd4;   opD[1] = 8'd255;
    opA[2] = 8'd128; opB[2] = 8'd1;   opD[2] = 8'd127;
    opA[3] = 8'd99;  opB[3] = 8'd99;  opD[3] = 8'd0;
    start = 1'b1; a = opA[0]; b = opB[0]; bin = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        a = opA[i+1];
        b = opB[i+1];
      end else begin
        start = 1'b0;
      end
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      checkOutput("t5_latency", n, W);
      checkOutput("t5_diff", diff, opD[i]);
      tick();
      checkOutput("t5_doneCleared", done, 0);
      checkOutput("t5_busyNext", busy, (i < 3) ? 1 : 0);
    end

    // Randomized operands against a modular reference.
    for (int i = 0; i < 200; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      applyStimulus(ra, rb, rbin, ref9[W-1:0], ref9[W], "t6");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
